// File: rtl/time_field_decoder_if.sv
// time_field_decoder_if: request/result bundle between a client and the seconds-to-fields decoder.
interface time_field_decoder_if #(
    parameter int T_WIDTH   = 28,
    parameter int DAY_WIDTH = 12
);
    logic [T_WIDTH-1:0]   t_in;
    logic                 start;
    logic                 auto_run;
    logic                 busy;
    logic                 done;
    logic                 valid;
    logic [DAY_WIDTH-1:0] day;
    logic [4:0]           hour;
    logic [5:0]           min;
    logic [5:0]           sec;
    modport master (output t_in, start, auto_run, input busy, done, valid, day, hour, min, sec);
    modport slave (input t_in, start, auto_run, output busy, done, valid, day, hour, min, sec);
endinterface

// File: rtl/time_field_decoder.sv
// time_field_decoder: flat seconds count to day/hour/min/sec via one shared restoring divider.
module time_field_decoder #(
    parameter int T_WIDTH   = 28,
    parameter int DAY_WIDTH = 12
) (
    input logic                 clk,
    input logic                 reset,
    time_field_decoder_if.slave bus
);
    localparam int CW = $clog2(T_WIDTH);
    typedef enum logic [2:0] {IDLE, DIV_DAY, DIV_HOUR, DIV_MIN, COMMIT} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [16:0]          rem_q, rem_d, rem_n;
    logic [T_WIDTH-1:0]   dvd_q, dvd_d;
    logic [DAY_WIDTH-1:0] day_h_q, day_h_d, day_q, day_d;
    logic [4:0]           hour_h_q, hour_h_d, hour_q, hour_d;
    logic [5:0]           min_h_q, min_h_d, min_q, min_d;
    logic [5:0]           sec_h_q, sec_h_d, sec_q, sec_d;
    logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [17:0]          divisor, trial;
    logic                 ge, req, dividing, last;
    assign divisor  = state_q == DIV_DAY ? 18'd86400 : state_q == DIV_HOUR ? 18'd3600 : 18'd60;
    assign trial    = {rem_q, dvd_q[T_WIDTH-1]};
    assign ge       = trial >= divisor;
    assign rem_n    = ge ? 17'(trial - divisor) : trial[16:0];
    assign req      = bus.start | (bus.auto_run & valid_q);
    assign dividing = state_q == DIV_DAY || state_q == DIV_HOUR || state_q == DIV_MIN;
    assign last     = cnt_q == '0;
    // Quotient bits shift straight into the holding registers; surplus leading zeros fall off the top.
    always_comb begin
        state_d  = state_q;
        cnt_d    = dividing ? cnt_q - CW'(1) : cnt_q;
        rem_d    = dividing ? rem_n : rem_q;
        dvd_d    = dividing ? dvd_q << 1 : dvd_q;
        day_h_d  = state_q == DIV_DAY ? {day_h_q[DAY_WIDTH-2:0], ge} : day_h_q;
        hour_h_d = state_q == DIV_HOUR ? {hour_h_q[3:0], ge} : hour_h_q;
        min_h_d  = state_q == DIV_MIN ? {min_h_q[4:0], ge} : min_h_q;
        sec_h_d  = sec_h_q;
        day_d    = day_q;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = DIV_DAY;
                dvd_d   = bus.t_in;
                rem_d   = '0;
                cnt_d   = CW'(T_WIDTH - 1);
                busy_d  = 1'b1;
            end
            DIV_DAY: if (last) begin
                state_d = DIV_HOUR;
                dvd_d   = T_WIDTH'(rem_n) << (T_WIDTH - 17);
                rem_d   = '0;
                cnt_d   = CW'(16);
            end
            DIV_HOUR: if (last) begin
                state_d = DIV_MIN;
                dvd_d   = T_WIDTH'(rem_n[11:0]) << (T_WIDTH - 12);
                rem_d   = '0;
                cnt_d   = CW'(11);
            end
            DIV_MIN: if (last) begin
                state_d = COMMIT;
                sec_h_d = rem_n[5:0];
                rem_d   = '0;
            end
            default: begin
                state_d = IDLE;
                day_d   = day_h_q;
                hour_d  = hour_h_q;
                min_d   = min_h_q;
                sec_d   = sec_h_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            day_h_q  <= '0;
            hour_h_q <= '0;
            min_h_q  <= '0;
            sec_h_q  <= '0;
            day_q    <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            day_h_q  <= day_h_d;
            hour_h_q <= hour_h_d;
            min_h_q  <= min_h_d;
            sec_h_q  <= sec_h_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.day   = day_q;
    assign bus.hour  = hour_q;
    assign bus.min   = min_q;
    assign bus.sec   = sec_q;
endmodule

// File: tb/tb_time_field_decoder.sv
// tb_time_field_decoder: scoreboard bench for time_field_decoder.
module tb_time_field_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0, fails = 0, cyc = 0, done_cnt = 0, n0 = 0;
    typedef struct {logic [27:0] t; int acc;} exp_t;
    exp_t sb[$];
    exp_t e;
    logic [28:0] last = '0;
    time_field_decoder_if b();
    time_field_decoder dut (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [28:0] model(input logic [27:0] t);
        return {12'(t / 86400), 5'(t % 86400 / 3600), 6'(t % 3600 / 60), 6'(t % 60)};
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic start_conv(input logic [27:0] t);
        for (int i = 0; i < 200 && b.busy; i++) tick;
        check("idle_before_start", b.busy, 0);
        b.t_in  = t;
        b.start = 1'b1;
        tick;
        sb.push_back('{t, cyc});
        b.start = 1'b0;
    endtask
    task automatic wait_done;
        int s = done_cnt;
        for (int i = 0; i < 100 && done_cnt == s; i++) tick;
        check("done_seen", done_cnt - s, 1);
    endtask
    always @(negedge clk) begin
        if (!reset && b.done) begin
            done_cnt++;
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("day", b.day, model(e.t) >> 17);
                check("hour", b.hour, (model(e.t) >> 12) & 29'h1f);
                check("min", b.min, (model(e.t) >> 6) & 29'h3f);
                check("sec", b.sec, model(e.t) & 29'h3f);
                check("latency", cyc - e.acc, 58);
                check("valid", b.valid, 1);
                last = model(e.t);
                if (b.auto_run) sb.push_back('{b.t_in, cyc + 1});
            end
        end else if (!reset && b.busy) check("hold", {b.day, b.hour, b.min, b.sec}, last);
    end
    initial begin
        logic [27:0] vec [5] = '{28'd0, 28'd90061, 28'd86399, 28'd86400, 28'hFFFFFFF};
        b.t_in = '0;
        b.start = 1'b0;
        b.auto_run = 1'b0;
        repeat (3) tick;
        check("rst_busy", b.busy, 0);
        check("rst_done", b.done, 0);
        check("rst_valid", b.valid, 0);
        check("rst_fields", {b.day, b.hour, b.min, b.sec}, 0);
        reset = 1'b0;
        tick;
        foreach (vec[i]) begin
            start_conv(vec[i]);
            wait_done;
        end
        start_conv(28'd12345);
        repeat (9) tick;
        b.start = 1'b1;
        b.t_in = 28'd999;
        tick;
        b.start = 1'b0;
        n0 = done_cnt;
        wait_done;
        repeat (70) tick;
        check("single_done", done_cnt - n0, 1);
        check("idle_after_ignored", b.busy, 0);
        start_conv(28'd50000);
        repeat (29) tick;
        reset = 1'b1;
        sb.delete();
        last = '0;
        #1;
        check("abort_busy", b.busy, 0);
        check("abort_done", b.done, 0);
        check("abort_valid", b.valid, 0);
        check("abort_fields", {b.day, b.hour, b.min, b.sec}, 0);
        repeat (2) tick;
        reset = 1'b0;
        n0 = done_cnt;
        repeat (70) tick;
        check("no_done_after_abort", done_cnt - n0, 0);
        b.auto_run = 1'b1;
        start_conv(28'd3661);
        repeat (3) wait_done;
        tick;
        b.auto_run = 1'b0;
        wait_done;
        repeat (70) tick;
        check("sb_empty", sb.size(), 0);
        check("auto_stopped", b.busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
